cpu_6502: RTL and testbench
===========================

# cpu_6502

Multi-cycle 8-bit CPU core implementing the 6502 load/store instruction subset with cycle-accurate bus behaviour. It is the processor block of the C64 design. It drives a flat 64 KB memory through a 16-bit address bus, a single read/write strobe and separate data-in and data-out buses. Memory read is combinational and memory write commits on the rising clock edge while `we` is high.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `di` in 8: read data; equals mem[`ab`] combinationally while `we`=0.
- `do` out 8: write data; meaningful only while `we`=1.
- `we` out 1: 1 = the current cycle is a write of `do` to `ab`; 0 = read.
- `ab` out 16: address bus, registered.

## Operation
- Internal registers:
  - PC (16 b), A, X, Y (8 b each).
  - N and Z flags; these update on every load and are not visible on any port.
  - IR (opcode), ADL/ADH (operand bytes), state.
- Reset values: PC=$0000, A=X=Y=0, N=Z=0, `ab`=$0000, `we`=0, `do`=$00, state=T0. There is no reset vector; execution starts at $0000.
- Supported opcodes:
  - LDA: A9 imm, A5 zp, AD abs, BD abs,X, B9 abs,Y
  - LDX: A2 imm, A6 zp, AE abs, BE abs,Y
  - LDY: A0 imm, A4 zp, AC abs, BC abs,X
  - STA: 85 zp, 8D abs, 9D abs,X, 99 abs,Y
  - STX: 86 zp, 8E abs
  - STY: 84 zp, 8C abs
  - EA NOP
- Any other opcode executes as a 1-byte, 2-cycle NOP: PC+1, no register or memory change.
- Cycle states:
  - T0: `ab`=PC; latch IR from `di`; PC+1.
  - T1: `ab`=PC; latch ADL. Immediate mode: load the register, PC+1, next T0. Otherwise PC+1.
  - T2 (absolute modes only): `ab`=PC; latch ADH; PC+1.
  - T3 (effective-address cycle):
    - zp: EA = $00:ADL.
    - abs: EA = ADH:ADL.
    - Indexed modes: `ab` = ADH:(ADL+idx) with the 8-bit sum wrapping and no high-byte carry.
    - Loads with no page carry complete here.
    - Stores: `we`=1, `do`=register.
    - A page carry on an indexed load makes this a dummy read; go to T4.
    - Indexed stores always use T4. T3 is then a dummy read with `we`=0.
  - T4: `ab` = (ADH + carry):(ADL+idx). Load or store completes here.
- Loads set Z = (value==0) and N = value[7]. Stores do not change flags.
- Address arithmetic is modulo 2^16. PC wraps $FFFF→$0000. A zero-page operand never leaves page 0.

## Timing
- Each state lasts one clock. `ab`, `we` and `do` are registered and change only after the rising edge, or on reset.
- In a read cycle, `di` is sampled at the rising edge that ends the cycle.
- In a write cycle, memory captures `do` at the same rising edge.
- Cycle counts:

  | Mode | Cycles |
  |---|---|
  | imm | 2 |
  | zp | 3 |
  | abs | 4 |
  | abs,X/Y load, no page cross | 4 |
  | abs,X/Y load, page cross | 5 |
  | abs,X/Y store (always) | 5 |
  | NOP / unknown | 2 |

- The opcode fetch of the next instruction follows immediately; there are no idle cycles.
- `we` is high for exactly one cycle per store and is never high in T0–T2.
- Reset asserted mid-instruction aborts at once: `we`→0 and `ab`→$0000 asynchronously, with no partial write. After release, the first rising edge performs T0 at $0000.

## Test plan
- Imm + abs store:
  - Program: A9 27, 8D 11 00, A2 21, 8E 16 00, A0 47, 8C 17 00.
  - Required: mem[$0011]=39, mem[$0016]=33, mem[$0017]=71.
  - The first write occurs in cycle 6 after reset release.
- Abs/zp:
  - Program: AE 00 04, 8E 40 04, A5 30, 85 35, with mem[$0400]=90 and mem[$30]=71.
  - Required: mem[$0440]=90, mem[$35]=71. Total 4+4+3+3 = 14 cycles.
- Indexed, no page cross:
  - Program: A2 05, A0 0B, BD 07 05, 99 10 05, with mem[$050C]=22.
  - Required: mem[$051B]=22. The LDA takes 4 cycles and the STA takes 5.
- Indexed with page cross:
  - Program: A2 05, A0 0B, BD FE 05, 99 FE 05, with mem[$0603]=22.
  - Required: dummy read of $0503, then a read of $0603, then a write of 22 to $0609.
  - The LDA takes 5 cycles; the STA shows a dummy read of $0509, then a write to $0609.
- Unknown opcode: 03 at $0000 consumes 2 cycles, and the next fetch is at $0001.
- Reset asserted during a store's T3: no memory write occurs, `ab`=$0000 and `we`=0 immediately, and execution restarts at $0000.

Source files
------------

// File: rtl/cpu_6502_if.sv
// Memory bus between the 6502 core and a flat 64 KB memory.
// The write-data line is named dout because "do" is a reserved word.
interface cpu_6502_if;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  dout;
  logic [7:0]  di;

  modport master (output ab, output we, output dout, input di);
  modport slave  (input ab, input we, input dout, output di);
endinterface

// File: rtl/cpu_6502.sv
// Multi-cycle 6502 core: load/store subset with cycle-accurate bus timing.
// ab/we/dout are registered; all next-cycle bus values come from one comb block.
module cpu_6502 (
  input  logic       clk,
  input  logic       reset,
  cpu_6502_if.master bus
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} state_t;
  typedef enum logic [2:0] {M_NOP, M_IMM, M_ZP, M_ABS, M_ABX, M_ABY} mode_t;
  typedef enum logic [1:0] {R_A, R_X, R_Y} reg_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [7:0]  r_a, w_a_nxt;
  logic [7:0]  r_x, w_x_nxt;
  logic [7:0]  r_y, w_y_nxt;
  logic        r_n, w_n_nxt;
  logic        r_z, w_z_nxt;
  logic [7:0]  r_ir, w_ir_nxt;
  logic [7:0]  r_adl, w_adl_nxt;
  logic [7:0]  r_adh, w_adh_nxt;
  logic        r_carry, w_carry_nxt;
  logic [15:0] r_ab, w_ab_nxt;
  logic        r_we, w_we_nxt;
  logic [7:0]  r_do, w_do_nxt;

  mode_t       w_mode;
  reg_t        w_reg;
  logic        w_store;
  logic        w_indexed;
  logic [7:0]  w_idx;
  logic [8:0]  w_sum;
  logic [7:0]  w_sreg;
  logic        w_ld;

  // Opcode decode: addressing mode, target register, load vs store
  always_comb begin
    w_mode  = M_NOP;
    w_reg   = R_A;
    w_store = 1'b0;
    case (r_ir)
      8'hA9: begin w_mode = M_IMM; w_reg = R_A; end
      8'hA5: begin w_mode = M_ZP;  w_reg = R_A; end
      8'hAD: begin w_mode = M_ABS; w_reg = R_A; end
      8'hBD: begin w_mode = M_ABX; w_reg = R_A; end
      8'hB9: begin w_mode = M_ABY; w_reg = R_A; end
      8'hA2: begin w_mode = M_IMM; w_reg = R_X; end
      8'hA6: begin w_mode = M_ZP;  w_reg = R_X; end
      8'hAE: begin w_mode = M_ABS; w_reg = R_X; end
      8'hBE: begin w_mode = M_ABY; w_reg = R_X; end
      8'hA0: begin w_mode = M_IMM; w_reg = R_Y; end
      8'hA4: begin w_mode = M_ZP;  w_reg = R_Y; end
      8'hAC: begin w_mode = M_ABS; w_reg = R_Y; end
      8'hBC: begin w_mode = M_ABX; w_reg = R_Y; end
      8'h85: begin w_mode = M_ZP;  w_reg = R_A; w_store = 1'b1; end
      8'h8D: begin w_mode = M_ABS; w_reg = R_A; w_store = 1'b1; end
      8'h9D: begin w_mode = M_ABX; w_reg = R_A; w_store = 1'b1; end
      8'h99: begin w_mode = M_ABY; w_reg = R_A; w_store = 1'b1; end
      8'h86: begin w_mode = M_ZP;  w_reg = R_X; w_store = 1'b1; end
      8'h8E: begin w_mode = M_ABS; w_reg = R_X; w_store = 1'b1; end
      8'h84: begin w_mode = M_ZP;  w_reg = R_Y; w_store = 1'b1; end
      8'h8C: begin w_mode = M_ABS; w_reg = R_Y; w_store = 1'b1; end
      default: begin w_mode = M_NOP; w_reg = R_A; w_store = 1'b0; end
    endcase
  end

  assign w_indexed = (w_mode == M_ABX) || (w_mode == M_ABY);
  assign w_idx     = (w_mode == M_ABX) ? r_x : ((w_mode == M_ABY) ? r_y : 8'h00);
  assign w_sum     = {1'b0, r_adl} + {1'b0, w_idx};
  assign w_sreg    = (w_reg == R_X) ? r_x : ((w_reg == R_Y) ? r_y : r_a);

  // Next-state, register and bus computation
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_a_nxt     = r_a;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_n_nxt     = r_n;
    w_z_nxt     = r_z;
    w_ir_nxt    = r_ir;
    w_adl_nxt   = r_adl;
    w_adh_nxt   = r_adh;
    w_carry_nxt = r_carry;
    w_ab_nxt    = r_ab;
    w_we_nxt    = 1'b0;
    w_do_nxt    = r_do;
    w_ld        = 1'b0;

    case (r_state)
      T0: begin
        w_ir_nxt    = bus.di;
        w_pc_nxt    = r_pc + 16'd1;
        w_ab_nxt    = r_pc + 16'd1;
        w_state_nxt = T1;
      end
      T1: begin
        w_adl_nxt = bus.di;
        case (w_mode)
          M_NOP: begin
            w_ab_nxt    = r_pc;
            w_state_nxt = T0;
          end
          M_IMM: begin
            w_ld        = 1'b1;
            w_pc_nxt    = r_pc + 16'd1;
            w_ab_nxt    = r_pc + 16'd1;
            w_state_nxt = T0;
          end
          M_ZP: begin
            w_pc_nxt    = r_pc + 16'd1;
            w_ab_nxt    = {8'h00, bus.di};
            w_we_nxt    = w_store;
            w_do_nxt    = w_store ? w_sreg : r_do;
            w_state_nxt = T3;
          end
          default: begin
            w_pc_nxt    = r_pc + 16'd1;
            w_ab_nxt    = r_pc + 16'd1;
            w_state_nxt = T2;
          end
        endcase
      end
      T2: begin
        // Indexed modes present the uncarried address first
        w_adh_nxt   = bus.di;
        w_pc_nxt    = r_pc + 16'd1;
        w_carry_nxt = w_sum[8];
        w_ab_nxt    = {bus.di, w_sum[7:0]};
        w_we_nxt    = w_store && !w_indexed;
        w_do_nxt    = (w_store && !w_indexed) ? w_sreg : r_do;
        w_state_nxt = T3;
      end
      T3: begin
        if (w_store && w_indexed) begin
          w_ab_nxt    = {r_adh + 8'(r_carry), r_ab[7:0]};
          w_we_nxt    = 1'b1;
          w_do_nxt    = w_sreg;
          w_state_nxt = T4;
        end else if (!w_store && w_indexed && r_carry) begin
          w_ab_nxt    = {r_adh + 8'h01, r_ab[7:0]};
          w_state_nxt = T4;
        end else begin
          w_ld        = !w_store;
          w_ab_nxt    = r_pc;
          w_state_nxt = T0;
        end
      end
      T4: begin
        w_ld        = !w_store;
        w_ab_nxt    = r_pc;
        w_state_nxt = T0;
      end
      default: begin
        w_ab_nxt    = r_pc;
        w_state_nxt = T0;
      end
    endcase

    if (w_ld) begin
      case (w_reg)
        R_A:     w_a_nxt = bus.di;
        R_X:     w_x_nxt = bus.di;
        default: w_y_nxt = bus.di;
      endcase
      w_n_nxt = bus.di[7];
      w_z_nxt = (bus.di == 8'h00);
    end
  end

  // State and register update; reset aborts any bus cycle immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= T0;
      r_pc    <= 16'h0000;
      r_a     <= 8'h00;
      r_x     <= 8'h00;
      r_y     <= 8'h00;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
      r_ir    <= 8'h00;
      r_adl   <= 8'h00;
      r_adh   <= 8'h00;
      r_carry <= 1'b0;
      r_ab    <= 16'h0000;
      r_we    <= 1'b0;
      r_do    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_a     <= w_a_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_n     <= w_n_nxt;
      r_z     <= w_z_nxt;
      r_ir    <= w_ir_nxt;
      r_adl   <= w_adl_nxt;
      r_adh   <= w_adh_nxt;
      r_carry <= w_carry_nxt;
      r_ab    <= w_ab_nxt;
      r_we    <= w_we_nxt;
      r_do    <= w_do_nxt;
    end
  end

  assign bus.ab   = r_ab;
  assign bus.we   = r_we;
  assign bus.dout = r_do;

endmodule

// File: tb/tb_cpu_6502.sv
// Bench for cpu_6502: an instruction-level model predicts every bus cycle,
// compared cycle by cycle and against final memory contents.
module tb_cpu_6502;

  localparam int MD_NOP = 0;
  localparam int MD_IMM = 1;
  localparam int MD_ZP  = 2;
  localparam int MD_ABS = 3;
  localparam int MD_ABX = 4;
  localparam int MD_ABY = 5;

  localparam logic [7:0] OPS [24] = '{
    8'hA9, 8'hA5, 8'hAD, 8'hBD, 8'hB9, 8'hA2, 8'hA6, 8'hAE, 8'hBE, 8'hA0, 8'hA4, 8'hAC,
    8'hBC, 8'h85, 8'h8D, 8'h9D, 8'h99, 8'h86, 8'h8E, 8'h84, 8'h8C, 8'hEA, 8'h03, 8'hFF};

  typedef struct {
    logic [15:0] ab;
    logic        we;
    logic [7:0]  d;
  } bus_t;

  logic clk;
  logic rst_n;

  logic [7:0] tb_mem [0:65535];
  logic [7:0] m_mem  [0:65535];
  logic [7:0] m_r    [3];
  logic [15:0] m_pc;
  bus_t q[$];

  int    n_checks;
  int    n_fail;
  int    cyc;
  int    first_we;
  string cur_test;
  logic [7:0] prog[$];

  cpu_6502_if bus ();

  cpu_6502 dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  assign bus.di = tb_mem[bus.ab];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h exp=%0h", cur_test, tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    tb_mem[a] = v;
    m_mem[a]  = v;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) poke(16'(i), 8'h00);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) poke(16'(i), prog[i]);
  endtask

  task automatic push(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus_t e;
    e.ab = a;
    e.we = w;
    e.d  = d;
    q.push_back(e);
  endtask

  // Opcode table: target register (0=A,1=X,2=Y), store flag, addressing mode
  task automatic decode(input logic [7:0] op, output int r, output bit st, output int md);
    r = 0; st = 1'b0; md = MD_NOP;
    case (op)
      8'hA9: begin r = 0; md = MD_IMM; end
      8'hA5: begin r = 0; md = MD_ZP;  end
      8'hAD: begin r = 0; md = MD_ABS; end
      8'hBD: begin r = 0; md = MD_ABX; end
      8'hB9: begin r = 0; md = MD_ABY; end
      8'hA2: begin r = 1; md = MD_IMM; end
      8'hA6: begin r = 1; md = MD_ZP;  end
      8'hAE: begin r = 1; md = MD_ABS; end
      8'hBE: begin r = 1; md = MD_ABY; end
      8'hA0: begin r = 2; md = MD_IMM; end
      8'hA4: begin r = 2; md = MD_ZP;  end
      8'hAC: begin r = 2; md = MD_ABS; end
      8'hBC: begin r = 2; md = MD_ABX; end
      8'h85: begin r = 0; md = MD_ZP;  st = 1'b1; end
      8'h8D: begin r = 0; md = MD_ABS; st = 1'b1; end
      8'h9D: begin r = 0; md = MD_ABX; st = 1'b1; end
      8'h99: begin r = 0; md = MD_ABY; st = 1'b1; end
      8'h86: begin r = 1; md = MD_ZP;  st = 1'b1; end
      8'h8E: begin r = 1; md = MD_ABS; st = 1'b1; end
      8'h84: begin r = 2; md = MD_ZP;  st = 1'b1; end
      8'h8C: begin r = 2; md = MD_ABS; st = 1'b1; end
      default: begin r = 0; md = MD_NOP; end
    endcase
  endtask

  task automatic access(input logic [15:0] ea, input int r, input bit st);
    if (st) push(ea, 1'b1, m_r[r]);
    else begin
      push(ea, 1'b0, 8'h00);
      m_r[r] = m_mem[ea];
    end
  endtask

  // Expand one instruction into its expected bus cycles
  task automatic model_step();
    logic [7:0]  op, lo, hi, idx;
    logic [15:0] ea, part;
    int r, md;
    bit st;
    op = m_mem[m_pc];
    push(m_pc, 1'b0, 8'h00);
    m_pc = m_pc + 16'd1;
    decode(op, r, st, md);
    if (md == MD_NOP) begin
      push(m_pc, 1'b0, 8'h00);
    end else begin
      lo = m_mem[m_pc];
      push(m_pc, 1'b0, 8'h00);
      m_pc = m_pc + 16'd1;
      if (md == MD_IMM) begin
        m_r[r] = lo;
      end else if (md == MD_ZP) begin
        access({8'h00, lo}, r, st);
      end else begin
        hi = m_mem[m_pc];
        push(m_pc, 1'b0, 8'h00);
        m_pc = m_pc + 16'd1;
        idx  = (md == MD_ABX) ? m_r[1] : ((md == MD_ABY) ? m_r[2] : 8'h00);
        ea   = {hi, lo} + {8'h00, idx};
        part = {hi, 8'(lo + idx)};
        if (md != MD_ABS && (st || part != ea)) push(part, 1'b0, 8'h00);
        access(ea, r, st);
      end
    end
  endtask

  // One bus cycle: compare at the falling edge, commit writes just before the rising edge
  task automatic do_cycle();
    bus_t e;
    @(negedge clk);
    if (q.size() == 0) model_step();
    e = q.pop_front();
    cyc++;
    check_eq("ab", 32'(bus.ab), 32'(e.ab));
    check_eq("we", 32'(bus.we), 32'(e.we));
    if (e.we) check_eq("do", 32'(bus.dout), 32'(e.d));
    if (bus.we && first_we == 0) first_we = cyc;
    #4;
    if (bus.we) tb_mem[bus.ab] = bus.dout;
    if (e.we) m_mem[e.ab] = e.d;
  endtask

  task automatic start_prog();
    rst_n = 1'b0;
    q.delete();
    m_pc = 16'h0000;
    for (int i = 0; i < 3; i++) m_r[i] = 8'h00;
    cyc = 0;
    first_we = 0;
    @(posedge clk);
    #1;
    check_eq("rst_ab", 32'(bus.ab), 32'h0000);
    check_eq("rst_we", 32'(bus.we), 32'h0);
    check_eq("rst_do", 32'(bus.dout), 32'h00);
    rst_n = 1'b1;
  endtask

  task automatic rand_prog();
    logic [7:0] op, lo, hi;
    int r, md, a;
    bit st;
    for (int i = 0; i < 65536; i++) poke(16'(i), 8'($urandom));
    a = 0;
    while (a < 120) begin
      op = OPS[$urandom_range(0, 23)];
      decode(op, r, st, md);
      lo = ($urandom_range(0, 2) == 0) ? 8'(8'hF0 + 8'($urandom_range(0, 15))) : 8'($urandom);
      case ($urandom_range(0, 3))
        0:       hi = 8'hFF;
        1:       hi = 8'h00;
        default: hi = 8'($urandom);
      endcase
      poke(16'(a), op);
      if (md != MD_NOP) poke(16'(a + 1), lo);
      if (md >= MD_ABS) poke(16'(a + 2), hi);
      a += (md == MD_NOP) ? 1 : ((md >= MD_ABS) ? 3 : 2);
    end
  endtask

  initial begin
    int diffs;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;

    cur_test = "imm_abs";
    clear_mem();
    prog = '{8'hA9, 8'h27, 8'h8D, 8'h11, 8'h00, 8'hA2, 8'h21, 8'h8E, 8'h16, 8'h00,
             8'hA0, 8'h47, 8'h8C, 8'h17, 8'h00};
    load_prog();
    start_prog();
    repeat (18) do_cycle();
    check_eq("m0011", 32'(tb_mem[16'h0011]), 32'd39);
    check_eq("m0016", 32'(tb_mem[16'h0016]), 32'd33);
    check_eq("m0017", 32'(tb_mem[16'h0017]), 32'd71);
    check_eq("first_we", 32'(first_we), 32'd6);

    cur_test = "abs_zp";
    clear_mem();
    prog = '{8'hAE, 8'h00, 8'h04, 8'h8E, 8'h40, 8'h04, 8'hA5, 8'h30, 8'h85, 8'h35};
    load_prog();
    poke(16'h0400, 8'd90);
    poke(16'h0030, 8'd71);
    start_prog();
    repeat (14) do_cycle();
    check_eq("m0440", 32'(tb_mem[16'h0440]), 32'd90);
    check_eq("m0035", 32'(tb_mem[16'h0035]), 32'd71);
    check_eq("first_we", 32'(first_we), 32'd8);

    cur_test = "idx_nocross";
    clear_mem();
    prog = '{8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'h07, 8'h05, 8'h99, 8'h10, 8'h05};
    load_prog();
    poke(16'h050C, 8'd22);
    start_prog();
    repeat (13) do_cycle();
    check_eq("m051B", 32'(tb_mem[16'h051B]), 32'd22);
    check_eq("first_we", 32'(first_we), 32'd13);

    cur_test = "idx_cross";
    clear_mem();
    prog = '{8'hA2, 8'h05, 8'hA0, 8'h0B, 8'hBD, 8'hFE, 8'h05, 8'h99, 8'hFE, 8'h05};
    load_prog();
    poke(16'h0603, 8'd22);
    start_prog();
    repeat (14) do_cycle();
    check_eq("m0609", 32'(tb_mem[16'h0609]), 32'd22);
    check_eq("m0509", 32'(tb_mem[16'h0509]), 32'd0);
    check_eq("first_we", 32'(first_we), 32'd14);

    cur_test = "unknown_op";
    clear_mem();
    poke(16'h0000, 8'h03);
    start_prog();
    repeat (2) do_cycle();
    @(negedge clk);
    check_eq("next_fetch", 32'(bus.ab), 32'h0001);

    cur_test = "reset_store";
    clear_mem();
    prog = '{8'hA9, 8'h27, 8'h8D, 8'h11, 8'h00};
    load_prog();
    start_prog();
    repeat (5) do_cycle();
    @(negedge clk);
    check_eq("pre_we", 32'(bus.we), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("async_ab", 32'(bus.ab), 32'h0000);
    check_eq("async_we", 32'(bus.we), 32'h0);
    #2;
    if (bus.we) tb_mem[bus.ab] = bus.dout;
    @(posedge clk);
    #1;
    check_eq("no_write", 32'(tb_mem[16'h0011]), 32'h00);
    start_prog();
    repeat (6) do_cycle();
    check_eq("restart_write", 32'(tb_mem[16'h0011]), 32'h27);
    check_eq("restart_first_we", 32'(first_we), 32'd6);

    for (int s = 0; s < 4; s++) begin
      cur_test = $sformatf("random%0d", s);
      rand_prog();
      start_prog();
      repeat (300) do_cycle();
      diffs = 0;
      for (int i = 0; i < 65536; i++) if (tb_mem[i] !== m_mem[i]) diffs++;
      check_eq("mem_diff", 32'(diffs), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
